// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator that sits behind the
// 4-bit Booth multiplier.
package product_accumulator_pkg;

  localparam int PROD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Clamp bounds of a w-bit two's complement accumulator.
  function automatic longint acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / result-out handshake bundle between multiplier, accumulator and
// the downstream consumer.
interface product_accumulator_if #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 5
);
  import product_accumulator_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              prod_ovf;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf_out;
  logic              busy;

  modport master (
    output start, len, in_valid, prod, prod_ovf, out_ready,
    input  in_ready, out_valid, acc_out, ovf_out, busy
  );

  modport slave (
    input  start, len, in_valid, prod, prod_ovf, out_ready,
    output in_ready, out_valid, acc_out, ovf_out, busy
  );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Combinational saturating add of a sign-extended product onto the accumulator,
// computed one bit wider than the accumulator so overflow is visible.
module sat_adder
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] w_sum_wide;

  assign w_sum_wide = {i_acc[ACC_W-1], i_acc}
                    + {{(ACC_W + 1 - PROD_W){i_prod[PROD_W-1]}}, i_prod};

  // The top two bits disagree only when the true sum left the ACC_W range.
  always_comb begin
    o_sum = w_sum_wide[ACC_W-1:0];
    o_sat = 1'b0;
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
      o_sat = 1'b1;
      o_sum = w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      o_sum = w_sum_wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of signed 4-bit products into a saturating
// accumulator at one product per cycle and hands the result downstream.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int CNT_W = 5
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_sum;
  logic             w_sat;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_len_nxt;

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .i_acc  (r_acc),
    .i_prod (bus.prod),
    .o_sum  (w_sum),
    .o_sat  (w_sat)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_len_nxt   = bus.len;
          w_state_nxt = (bus.len != '0) ? ST_ACCUM : ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        // in_ready is implied by being in ACCUM, so in_valid alone is a beat.
        if (bus.in_valid) begin
          w_acc_nxt = w_sum;
          w_ovf_nxt = r_ovf | bus.prod_ovf | w_sat;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.acc_out   = r_acc;
  assign bus.ovf_out   = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized checks of product_accumulator against an integer
// saturating-sum model.
module tb_product_accumulator;

  localparam int ACC_W = 8;
  localparam int CNT_W = 5;
  localparam int HI    = (1 << (ACC_W - 1)) - 1;
  localparam int LO    = -(1 << (ACC_W - 1));

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus();

  product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int m_acc;
  bit m_ovf;
  int prod_q[$];
  bit povf_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_beat(input int p, input bit f);
    int s;
    bit sat;
    s   = m_acc + p;
    sat = 1'b0;
    if (s > HI) begin
      s   = HI;
      sat = 1'b1;
    end else if (s < LO) begin
      s   = LO;
      sat = 1'b1;
    end
    m_acc = s;
    m_ovf = m_ovf | f | sat;
  endfunction

  function automatic logic [31:0] exp_acc();
    logic [ACC_W-1:0] v;
    v = m_acc[ACC_W-1:0];
    return {{(32 - ACC_W){1'b0}}, v};
  endfunction

  // One complete run: start, feed prod_q/povf_q, then drain the result.
  task automatic run(input int len, input int gap_pct, input int hold,
                     input bit early_ready, input bit noise);
    int idx;
    int cyc;
    int budget;
    bit v;
    idx   = 0;
    m_acc = 0;
    m_ovf = 1'b0;
    bus.len       = CNT_W'(len);
    bus.start     = 1'b1;
    bus.out_ready = early_ready;
    tick();
    bus.start = 1'b0;
    cyc       = 1;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    if (len != 0) begin
      check("in_ready_after_start", {31'd0, bus.in_ready}, 32'd1);
      check("no_out_valid_accum", {31'd0, bus.out_valid}, 32'd0);
      budget = len * 20 + 50;
      while (idx < len && cyc < budget) begin
        v = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
        bus.in_valid = v;
        bus.prod     = 4'(prod_q[idx]);
        bus.prod_ovf = povf_q[idx];
        if (noise) begin
          bus.start = 1'($urandom_range(1));
          bus.len   = CNT_W'($urandom);
        end
        @(posedge clk);
        if (v) begin
          model_beat(prod_q[idx], povf_q[idx]);
          idx++;
        end
        #1;
        cyc++;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (v) begin
          check("acc_running", {24'd0, bus.acc_out}, exp_acc());
          check("ovf_running", {31'd0, bus.ovf_out}, {31'd0, m_ovf});
        end
        if (idx < len) check("in_ready_mid", {31'd0, bus.in_ready}, 32'd1);
      end
      check("beats_consumed", idx, len);
    end
    check("out_valid_done", {31'd0, bus.out_valid}, 32'd1);
    check("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
    check("acc_done", {24'd0, bus.acc_out}, exp_acc());
    check("ovf_done", {31'd0, bus.ovf_out}, {31'd0, m_ovf});
    if (gap_pct == 0) check("latency", cyc, len + 1);
    if (!early_ready) begin
      for (int h = 0; h < hold; h++) begin
        if (noise) begin
          bus.start    = 1'b1;
          bus.len      = CNT_W'($urandom);
          bus.in_valid = 1'b1;
          bus.prod     = 4'($urandom);
        end
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_acc", {24'd0, bus.acc_out}, exp_acc());
        check("hold_ovf", {31'd0, bus.ovf_out}, {31'd0, m_ovf});
      end
      bus.out_ready = 1'b1;
    end
    tick();
    check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check("busy_drop", {31'd0, bus.busy}, 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.prod     = '0;
    bus.prod_ovf = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_acc", {24'd0, bus.acc_out}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf_out}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic sum 3 - 2 + 5 = 6.
    prod_q = '{3, -2, 5};
    povf_q = '{1'b0, 1'b0, 1'b0};
    run(3, 0, 2, 1'b0, 1'b0);

    // Positive saturation, out_ready held high throughout.
    prod_q.delete(); povf_q.delete();
    for (int i = 0; i < 20; i++) begin prod_q.push_back(7); povf_q.push_back(1'b0); end
    run(20, 0, 0, 1'b1, 1'b0);

    // Negative saturation: -128 reached exactly, then the 17th term clamps.
    prod_q.delete(); povf_q.delete();
    for (int i = 0; i < 17; i++) begin prod_q.push_back(-8); povf_q.push_back(1'b0); end
    run(17, 0, 1, 1'b0, 1'b0);

    // Upstream overflow flag, then zero length.
    prod_q = '{1, 1};
    povf_q = '{1'b0, 1'b1};
    run(2, 0, 0, 1'b0, 1'b0);
    run(0, 0, 0, 1'b0, 1'b0);
    run(0, 0, 0, 1'b1, 1'b0);

    // Random runs with input gaps, ignored starts and DONE backpressure.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = (r == 0) ? 12 : int'($urandom_range(31, 1));
      prod_q.delete(); povf_q.delete();
      for (int i = 0; i < n; i++) begin
        prod_q.push_back(int'($urandom_range(15)) - 8);
        povf_q.push_back($urandom_range(9) == 0);
      end
      run(n, 40, (r == 0) ? 5 : int'($urandom_range(5)), 1'b0, 1'b1);
    end

    // Reset asserted after 2 of 5 terms.
    bus.len   = CNT_W'(5);
    bus.start = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.prod     = 4'd2;
    bus.prod_ovf = 1'b1;
    tick();
    tick();
    check("pre_rst_acc", {24'd0, bus.acc_out}, 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_acc", {24'd0, bus.acc_out}, 32'd0);
    check("mid_rst_ovf", {31'd0, bus.ovf_out}, 32'd0);
    bus.in_valid = 1'b0;
    bus.prod_ovf = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    prod_q = '{-3};
    povf_q = '{1'b0};
    run(1, 0, 1, 1'b0, 1'b0);
    check("post_rst_fd", {24'd0, bus.acc_out}, 32'h0000_00FD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulator directly downstream of the 4-bit Booth multiplier. It consumes a stream of signed 4-bit products plus their overflow flag over a valid/ready handshake, and sums a programmed number of terms into a saturating signed accumulator. It then presents the sum and a sticky overflow flag on an output handshake. One product is accepted per cycle, so the multiplier stage runs at full rate.

## Interface
- `ACC_W`, default 8: accumulator width in bits, two's complement.
- `CNT_W`, default 5: width of the term-count field.
- `clk`  in  1  clock; all registers update on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run; sampled only in IDLE.
- `len`  in  CNT_W  number of products to accumulate; sampled with `start`.
- `in_valid`  in  1  a product is present on `prod`/`prod_ovf`.
- `in_ready`  out  1  the block accepts a product this cycle.
- `prod`  in  4  signed product from the multiplier.
- `prod_ovf`  in  1  the multiplier's overflow flag for `prod`.
- `out_valid`  out  1  `acc_out`/`ovf_out` hold the final result.
- `out_ready`  in  1  downstream accepts the result.
- `acc_out`  out  ACC_W  signed accumulated sum.
- `ovf_out`  out  1  sticky overflow flag for the run.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `start`=1, `len`≠0: clear acc, count and ovf; latch `len`; go to ACCUM.
  - `start`=1, `len`=0: clear acc and ovf; go directly to DONE.
- ACCUM:
  - `in_ready`=1.
  - A beat is accepted when `in_valid`&`in_ready`:
    - acc ← sat(acc + sign_extend(prod)).
    - ovf ← ovf | prod_ovf | sat_event.
    - count++.
  - When the accepted beat brings count to the latched `len`, go to DONE.
- DONE:
  - `out_valid`=1, with `acc_out`/`ovf_out` held stable.
  - On `out_ready`=1, go to IDLE.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - A result above 2^(ACC_W-1)-1 clamps to that value; a result below -2^(ACC_W-1) clamps to -2^(ACC_W-1).
  - Either clamp asserts sat_event.
  - Once saturated, further terms keep adding to the clamped value; there is no wrap-around.
- `start` is ignored outside IDLE.
- `in_valid` is ignored outside ACCUM, and no beat is consumed.
- `in_ready` is 0 in IDLE and DONE.
- Reset mid-operation: all state returns to IDLE immediately and any partial sum is discarded.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - `acc_out`=0, `ovf_out`=0.
  - Internal count=0, latched `len`=0.
- `in_ready`, `out_valid` and `busy` decode from the registered state only; there is no combinational path from any input.
- `start` in cycle t:
  - `busy`=1 from cycle t+1.
  - `in_ready`=1 from t+1 (len≠0).
  - `out_valid`=1 at t+1 (len=0).
- Last beat accepted in cycle t → `out_valid`=1 in cycle t+1.
- Throughput is one product per cycle; a run of N terms takes at least N+1 cycles from `start` to `out_valid`.
- `out_valid`=1 and `out_ready`=1 in cycle t → `out_valid`=0 and state IDLE at t+1. A new `start` is honoured at t+1 at the earliest.
- `out_ready` held high before DONE: the result is still presented for exactly one cycle.

## Structure
- Shared package holds:
  - The state enum (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2).
  - ACC_MAX/ACC_MIN constants derived from ACC_W.
  - The product width constant (4).
- One sub-module, `sat_adder`:
  - Combinational (ACC_W+1)-bit add with clamp.
  - Outputs the clamped sum and sat_event.
- The FSM, counter and output registers live in the top block.

## Test plan
- Basic sum:
  - Stimulus: `start`, `len`=3; products 3, -2, 5; all `prod_ovf`=0; `in_valid` continuous.
  - Response: `out_valid` 4 cycles after `start`; `acc_out`=6, `ovf_out`=0.
- Positive saturation:
  - Stimulus: `len`=20; all products 7.
  - Response: acc=126 after 18 terms, clamps to 127 on the 19th and stays 127; final `acc_out`=127, `ovf_out`=1.
- Negative saturation:
  - Stimulus: `len`=17; all products -8.
  - Response: acc=-128 after 16 terms with no sat_event; the 17th term clamps; final `acc_out`=-128, `ovf_out`=1.
- Upstream overflow and zero length:
  - Stimulus: `len`=2; products 1, 1 with `prod_ovf`=1 on the second.
  - Response: `acc_out`=2, `ovf_out`=1.
  - Follow-up: `len`=0 gives `out_valid` the next cycle with `acc_out`=0.
- Backpressure and gaps:
  - Stimulus: `in_valid` toggled randomly; `out_ready` held low 5 cycles in DONE.
  - Response: only handshaked beats are counted; the result stays stable until `out_ready`; `start` pulses during ACCUM/DONE are ignored.
- Async reset mid-run:
  - Stimulus: assert `rst` after 2 of 5 terms.
  - Response: outputs go to their reset values immediately; a fresh run with `len`=1, `prod`=-3 yields `acc_out`=-3 (0xFD).
